// File: rtl/dac_sched_pkg.sv
// Shared types and defaults for the dual-port DAC source scheduler.
// Fade sequencing is built only when DAC_SCHED_SOFT_FADE_EN is defined.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    StPass,
    StFadeOut,
    StSwitch,
    StFadeIn
  } port_state_t;

  localparam int unsigned DefW         = 14;
  localparam int unsigned DefNsrc      = 4;
  localparam int unsigned DefFadeLog2  = 4;
  localparam int unsigned DefFullGain  = 32'd1 << DefFadeLog2;

  // Unity gain in the gain register's fixed-point format.
  function automatic int unsigned full_gain(input int unsigned fade_log2);
    return 32'd1 << fade_log2;
  endfunction

endpackage

// File: rtl/dac_source_scheduler_if.sv
// Source-switch request channel: valid/ready handshake carrying target port and source index.
interface dac_source_scheduler_if #(
  parameter int unsigned SelW = 2
);
  logic            cfg_valid;
  logic            cfg_port;
  logic [SelW-1:0] cfg_sel;
  logic            cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_port,
    output cfg_sel,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_port,
    input  cfg_sel,
    output cfg_ready
  );
endinterface

// File: rtl/dac_port_seq.sv
// One DAC port: source select FSM, fade gain counter, source mux and scaled output register.
// With DAC_SCHED_SOFT_FADE_EN defined the port fades out, swaps source and fades back in;
// otherwise the gain is fixed at unity and a switch takes a single SWITCH cycle.
module dac_port_seq
  import dac_sched_pkg::*;
#(
  parameter int unsigned W         = DefW,
  parameter int unsigned NSRC      = DefNsrc,
  parameter int unsigned FADE_LOG2 = DefFadeLog2,
  parameter int unsigned SELW      = (NSRC > 1) ? $clog2(NSRC) : 1,
  parameter int unsigned RST_SEL   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC*W-1:0] src_data_i,
  input  logic              req_i,
  input  logic [SELW-1:0]   req_sel_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic [SELW-1:0]   sel_o,
  output logic [W-1:0]      out_o
);

  localparam int unsigned GW = FADE_LOG2 + 1;
  localparam logic [GW-1:0] GFull = GW'(full_gain(FADE_LOG2));
  localparam logic [SELW-1:0] RstSel = SELW'(RST_SEL);

  port_state_t     state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] pending_q, pending_d;
  logic [GW-1:0]   g;
  logic [W-1:0]    out_q, out_d;
  logic            sel_in_range;

`ifdef DAC_SCHED_SOFT_FADE_EN
  logic [GW-1:0] g_q, g_d;
  assign g = g_q;
`else
  assign g = GFull;
`endif

  // Out-of-range selects are silently dropped; a power-of-two NSRC has none.
  if (NSRC == (2 ** SELW)) begin : g_sel_full
    assign sel_in_range = 1'b1;
  end else begin : g_sel_part
    assign sel_in_range = (req_sel_i < SELW'(NSRC));
  end

  // Next-state logic for the switch sequence and the gain ramp.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    pending_d = pending_q;
`ifdef DAC_SCHED_SOFT_FADE_EN
    g_d       = g_q;
`endif
    unique case (state_q)
      StPass: begin
        if (req_i && sel_in_range && (req_sel_i != sel_q)) begin
          pending_d = req_sel_i;
`ifdef DAC_SCHED_SOFT_FADE_EN
          state_d   = StFadeOut;
`else
          state_d   = StSwitch;
`endif
        end
      end
`ifdef DAC_SCHED_SOFT_FADE_EN
      StFadeOut: begin
        g_d = g_q - 1'b1;
        if (g_d == '0) state_d = StSwitch;
      end
      StFadeIn: begin
        g_d = g_q + 1'b1;
        if (g_d == GFull) state_d = StPass;
      end
`endif
      StSwitch: begin
        sel_d = pending_q;
`ifdef DAC_SCHED_SOFT_FADE_EN
        state_d = StFadeIn;
`else
        state_d = StPass;
`endif
      end
      default: state_d = StPass;
    endcase
  end

  // Scaled sample: signed product then floor shift, low W bits kept.
  logic signed [W-1:0]    src_x;
  logic signed [W+GW-1:0] prod;
  assign src_x = src_data_i[sel_q*W +: W];
  assign prod  = (W+GW)'(src_x) * $signed({{W{1'b0}}, g});
  assign out_d = W'(prod >>> FADE_LOG2);

  // State, select, gain and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StPass;
      sel_q     <= RstSel;
      pending_q <= RstSel;
      out_q     <= '0;
`ifdef DAC_SCHED_SOFT_FADE_EN
      g_q       <= GFull;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      out_q     <= out_d;
`ifdef DAC_SCHED_SOFT_FADE_EN
      g_q       <= g_d;
`endif
    end
  end

  assign ready_o = (state_q == StPass);
  assign busy_o  = (state_q != StPass);
  assign sel_o   = sel_q;
  assign out_o   = out_q;

endmodule

// File: rtl/dac_source_scheduler.sv
// Dual-port DAC source scheduler: two independent port sequencers behind one request channel.
// Soft fading on switch is enabled by DAC_SCHED_SOFT_FADE_EN (see dac_port_seq).
module dac_source_scheduler
  import dac_sched_pkg::*;
#(
  parameter int unsigned W         = DefW,
  parameter int unsigned NSRC      = DefNsrc,
  parameter int unsigned FADE_LOG2 = DefFadeLog2,
  localparam int unsigned SELW     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*W-1:0]    src_data_i,
  dac_source_scheduler_if.slave cfg_if,
  output logic [W-1:0]         dac_a_out_o,
  output logic [W-1:0]         dac_b_out_o,
  output logic [SELW-1:0]      sel_a_o,
  output logic [SELW-1:0]      sel_b_o,
  output logic                 busy_a_o,
  output logic                 busy_b_o
);

  logic req_a, req_b;
  logic ready_a, ready_b;

  assign req_a = cfg_if.cfg_valid & ~cfg_if.cfg_port;
  assign req_b = cfg_if.cfg_valid &  cfg_if.cfg_port;
  assign cfg_if.cfg_ready = cfg_if.cfg_port ? ready_b : ready_a;

  dac_port_seq #(
    .W         (W),
    .NSRC      (NSRC),
    .FADE_LOG2 (FADE_LOG2),
    .SELW      (SELW),
    .RST_SEL   (0)
  ) u_port_a (
    .clk        (clk),
    .rst        (rst),
    .src_data_i (src_data_i),
    .req_i      (req_a),
    .req_sel_i  (cfg_if.cfg_sel),
    .ready_o    (ready_a),
    .busy_o     (busy_a_o),
    .sel_o      (sel_a_o),
    .out_o      (dac_a_out_o)
  );

  dac_port_seq #(
    .W         (W),
    .NSRC      (NSRC),
    .FADE_LOG2 (FADE_LOG2),
    .SELW      (SELW),
    .RST_SEL   (1 % NSRC)
  ) u_port_b (
    .clk        (clk),
    .rst        (rst),
    .src_data_i (src_data_i),
    .req_i      (req_b),
    .req_sel_i  (cfg_if.cfg_sel),
    .ready_o    (ready_b),
    .busy_o     (busy_b_o),
    .sel_o      (sel_b_o),
    .out_o      (dac_b_out_o)
  );

endmodule

// File: tb/tb_dac_source_scheduler.sv
// Self-checking bench for dac_source_scheduler; follows DAC_SCHED_SOFT_FADE_EN when defined.
module tb_dac_source_scheduler;

  localparam int W    = 14;
  localparam int NSRC = 4;
  localparam int F    = 4;
  localparam int SELW = 2;
  localparam int FULL = 1 << F;
`ifdef DAC_SCHED_SOFT_FADE_EN
  localparam bit Fade = 1'b1;
`else
  localparam bit Fade = 1'b0;
`endif
  // Cycles after the accept edge at which the select flips and the port is idle again.
  localparam int SwK  = Fade ? FULL + 1 : 1;
  localparam int EndK = Fade ? 2 * FULL + 1 : 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NSRC*W-1:0] src_data = '0;
  logic [W-1:0]      dac_a, dac_b;
  logic [SELW-1:0]   sel_a, sel_b;
  logic              busy_a, busy_b;

  dac_source_scheduler_if #(.SelW(SELW)) cfg_if ();

  dac_source_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .src_data_i  (src_data),
    .cfg_if      (cfg_if),
    .dac_a_out_o (dac_a),
    .dac_b_out_o (dac_b),
    .sel_a_o     (sel_a),
    .sel_b_o     (sel_b),
    .busy_a_o    (busy_a),
    .busy_b_o    (busy_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: each port is idle or k edges into a switch timeline.
  bit           m_act [2];
  int           m_k   [2];
  int           m_sel [2];
  int           m_new [2];
  logic [W-1:0] m_out [2];

  function automatic int g_of(input int p);
    if (!m_act[p] || !Fade) return FULL;
    if (m_k[p] <= FULL) return FULL - m_k[p];
    return m_k[p] - FULL - 1;
  endfunction

  function automatic int sel_of(input int p);
    if (m_act[p] && m_k[p] >= SwK) return m_new[p];
    return m_sel[p];
  endfunction

  function automatic int src_val(input int k);
    logic [W-1:0] v;
    v = src_data[k*W +: W];
    return int'($signed(v));
  endfunction

  function automatic logic [W-1:0] scale(input int x, input int g);
    longint pr;
    pr = (longint'(x) * longint'(g)) >>> F;
    return pr[W-1:0];
  endfunction

  task automatic model_reset();
    m_act[0] = 1'b0; m_act[1] = 1'b0;
    m_k[0] = 0;      m_k[1] = 0;
    m_sel[0] = 0;    m_sel[1] = 1 % NSRC;
    m_new[0] = 0;    m_new[1] = 1 % NSRC;
    m_out[0] = '0;   m_out[1] = '0;
  endtask

  task automatic set_src(input int k, input int v);
    src_data[k*W +: W] = W'(v);
  endtask

  // Advance one clock edge and update the model with the inputs seen at that edge.
  task automatic tick();
    int xs [2];
    int gp [2];
    bit acc;
    int cp, cs;
    for (int p = 0; p < 2; p++) begin
      xs[p] = src_val(sel_of(p));
      gp[p] = g_of(p);
    end
    cp  = int'(cfg_if.cfg_port);
    cs  = int'(cfg_if.cfg_sel);
    acc = cfg_if.cfg_valid && !m_act[cp];
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        m_out[p] = scale(xs[p], gp[p]);
        if (m_act[p]) begin
          m_k[p]++;
          if (m_k[p] >= EndK) begin
            m_act[p] = 1'b0;
            m_sel[p] = m_new[p];
          end
        end else if (acc && cp == p && cs < NSRC && cs != m_sel[p]) begin
          m_act[p] = 1'b1;
          m_k[p]   = 0;
          m_new[p] = cs;
        end
      end
    end
  endtask

  task automatic request(input bit port, input int s);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_port  = port;
    cfg_if.cfg_sel   = SELW'(s);
  endtask

  task automatic idle_cfg();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_port  = 1'b0;
    cfg_if.cfg_sel   = '0;
  endtask

  task automatic test_reset();
    model_reset();
    idle_cfg();
    tick();
    tick();
    #2 rst = 1'b0;
    // Move both ports away from their reset selects.
    request(1'b0, 2);
    tick();
    request(1'b1, 3);
    tick();
    idle_cfg();
    for (int i = 0; i < 40; i++) tick();
    #2 rst = 1'b1;
    #1;
    total++; if (sel_a !== 2'd0) begin bad++; $display("FAIL reset_sel_a got=%0d exp=0", sel_a); end
    total++; if (sel_b !== 2'd1) begin bad++; $display("FAIL reset_sel_b got=%0d exp=1", sel_b); end
    total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b%b exp=00", busy_a, busy_b);
    end
    total++; if (dac_a !== '0 || dac_b !== '0) begin
      bad++; $display("FAIL reset_dac got=%0h/%0h exp=0/0", dac_a, dac_b);
    end
    total++; if (cfg_if.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready);
    end
    model_reset();
    tick();
    #2 rst = 1'b0;
  endtask

  task automatic test_passthrough();
    set_src(0, 'h1234);
    set_src(1, -5);
    tick();
    total++; if (dac_a !== 14'h1234) begin bad++; $display("FAIL pass_a got=%0h exp=1234", dac_a); end
    total++; if (dac_b !== 14'h3ffb) begin bad++; $display("FAIL pass_b got=%0h exp=3ffb", dac_b); end
  endtask

  task automatic test_fade();
    int busy_cnt;
    int ev;
    logic [W-1:0] e;
    set_src(0, 1600);
    set_src(1, 777);
    set_src(2, -1600);
    request(1'b0, 2);
    #1;
    total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL fade_ready got=%b exp=1", cfg_if.cfg_ready); end
    tick();
    idle_cfg();
    busy_cnt = busy_a ? 1 : 0;
    for (int k = 0; k < 36; k++) begin
      tick();
      ev = (k <= 16) ? 100 * (16 - k) : ((k <= 33) ? -100 * (k - 17) : -1600);
      e  = W'(ev);
      total++; if (dac_a !== e) begin bad++; $display("FAIL fade_out k=%0d got=%0h exp=%0h", k, dac_a, e); end
      total++; if (busy_a !== ((k + 1) <= 32)) begin
        bad++; $display("FAIL fade_busy k=%0d got=%b exp=%b", k, busy_a, (k + 1) <= 32);
      end
      total++; if (sel_a !== (((k + 1) >= 17) ? 2'd2 : 2'd0)) begin
        bad++; $display("FAIL fade_sel k=%0d got=%0d", k, sel_a);
      end
      total++; if (dac_b !== 14'd777) begin bad++; $display("FAIL fade_b k=%0d got=%0h exp=309", k, dac_b); end
      if (busy_a) busy_cnt++;
    end
    total++; if (busy_cnt !== 33) begin bad++; $display("FAIL fade_busy_len got=%0d exp=33", busy_cnt); end
  endtask

  task automatic test_stall();
    int t1, t2, n;
    bit stalled, accepted;
    t1 = (m_sel[0] + 1) % NSRC;
    t2 = (t1 + 1) % NSRC;
    request(1'b0, t1);
    tick();
    request(1'b0, t2);
    stalled  = 1'b0;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 100) begin
      #1;
      total++; if (cfg_if.cfg_ready !== !m_act[0]) begin
        bad++; $display("FAIL stall_ready n=%0d got=%b exp=%b", n, cfg_if.cfg_ready, !m_act[0]);
      end
      if (cfg_if.cfg_ready === 1'b0) stalled = 1'b1;
      if (cfg_if.cfg_ready === 1'b1) accepted = 1'b1;
      cfg_if.cfg_port = 1'b1;
      #1;
      total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL stall_other got=%b exp=1", cfg_if.cfg_ready); end
      cfg_if.cfg_port = 1'b0;
      tick();
      n++;
    end
    idle_cfg();
    total++; if (!accepted || !stalled) begin
      bad++; $display("FAIL stall_accept got=acc%0d/stall%0d exp=1/1", accepted, stalled);
    end
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin tick(); n++; end
    total++; if (sel_a !== SELW'(t2)) begin bad++; $display("FAIL stall_sel got=%0d exp=%0d", sel_a, t2); end
  endtask

  task automatic test_noop();
    int cur;
    cur = m_sel[0];
    request(1'b0, cur);
    tick();
    idle_cfg();
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL noop_busy0 got=%b exp=0", busy_a); end
    tick();
    total++; if (busy_a !== 1'b0 || sel_a !== SELW'(cur)) begin
      bad++; $display("FAIL noop_busy1 got=%b/%0d exp=0/%0d", busy_a, sel_a, cur);
    end
  endtask

  task automatic test_reset_mid_fade();
    request(1'b0, (m_sel[0] + 1) % NSRC);
    tick();
    idle_cfg();
    for (int i = 0; i < 9; i++) tick();
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy got=%b exp=1", busy_a); end
    #2 rst = 1'b1;
    #1;
    total++; if (sel_a !== 2'd0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL midrst got=sel%0d/busy%b exp=sel0/busy0", sel_a, busy_a);
    end
    total++; if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", cfg_if.cfg_ready); end
    model_reset();
    tick();
    #2 rst = 1'b0;
    set_src(0, -4321);
    tick();
    total++; if (dac_a !== W'(-4321)) begin bad++; $display("FAIL midrst_full got=%0h exp=%0h", dac_a, W'(-4321)); end
  endtask

  task automatic test_switch_nofade();
    int old, tgt;
    old = m_sel[0];
    tgt = (old == 3) ? 2 : 3;
    for (int k = 0; k < NSRC; k++) set_src(k, 1000 + 111 * k);
    request(1'b0, tgt);
    tick();
    idle_cfg();
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL nf_busy0 got=%b exp=1", busy_a); end
    tick();
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL nf_busy1 got=%b exp=0", busy_a); end
    total++; if (dac_a !== W'(1000 + 111 * old)) begin
      bad++; $display("FAIL nf_out1 got=%0d exp=%0d", dac_a, 1000 + 111 * old);
    end
    tick();
    total++; if (dac_a !== W'(1000 + 111 * tgt)) begin
      bad++; $display("FAIL nf_out2 got=%0d exp=%0d", dac_a, 1000 + 111 * tgt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NSRC; k++) set_src(k, int'($urandom));
      cfg_if.cfg_valid = ($urandom_range(0, 9) < 3);
      cfg_if.cfg_port  = 1'($urandom);
      cfg_if.cfg_sel   = SELW'($urandom);
      #1;
      total++; if (cfg_if.cfg_ready !== !m_act[int'(cfg_if.cfg_port)]) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%b", c, cfg_if.cfg_ready);
      end
      tick();
      total++; if (dac_a !== m_out[0] || dac_b !== m_out[1]) begin
        bad++; $display("FAIL rnd_out c=%0d got=%0h/%0h exp=%0h/%0h", c, dac_a, dac_b, m_out[0], m_out[1]);
      end
      total++; if (sel_a !== SELW'(sel_of(0)) || sel_b !== SELW'(sel_of(1))) begin
        bad++; $display("FAIL rnd_sel c=%0d got=%0d/%0d exp=%0d/%0d", c, sel_a, sel_b, sel_of(0), sel_of(1));
      end
      total++; if (busy_a !== m_act[0] || busy_b !== m_act[1]) begin
        bad++; $display("FAIL rnd_busy c=%0d got=%b%b exp=%b%b", c, busy_a, busy_b, m_act[0], m_act[1]);
      end
    end
    idle_cfg();
  endtask

  initial begin
    test_reset();
    test_passthrough();
`ifdef DAC_SCHED_SOFT_FADE_EN
    test_fade();
`endif
    test_stall();
    test_noop();
`ifdef DAC_SCHED_SOFT_FADE_EN
    test_reset_mid_fade();
`else
    test_switch_nofade();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dac_source_scheduler.md
# dac_source_scheduler

Sequences which sample source drives each of the two DAC ports (A and B) on the dual-port high-speed DAC path. Accepts source-switch requests over a valid/ready handshake. On each switch it fades the affected port to zero, swaps the source, and fades back in, so the analog output never steps abruptly. Sits between the modulators/ADC loopback and the DAC pin driver; outputs are two's complement, and offset-binary conversion stays downstream.

## Interface
- `W`, 14, sample width in bits (two's complement)
- `NSRC`, 4, number of selectable sources; `SELW = $clog2(NSRC)`
- `FADE_LOG2`, 4, fade length is 2^FADE_LOG2 cycles per direction
- `clk` in 1: sample clock, same clock as the DAC write/clock pins
- `rst` in 1: asynchronous, active-high reset
- `src_data` in NSRC*W: source k occupies bits [k*W +: W]; a new sample every cycle
- `cfg_valid` in 1: switch request
- `cfg_port` in 1: target port; 0 = A, 1 = B
- `cfg_sel` in SELW: requested source index
- `cfg_ready` out 1: request accepted on an edge with `cfg_valid && cfg_ready`
- `dac_a_out` / `dac_b_out` out W: scaled samples for each port
- `sel_a` / `sel_b` out SELW: source currently routed to each port
- `busy_a` / `busy_b` out 1: port not in PASS

## Operation
- Two independent port sequencers, each with state {PASS, FADE_OUT, SWITCH, FADE_IN}, a gain register `g` (FADE_LOG2+1 bits, unsigned) and a `pending` select.
- `cfg_ready` is combinational: high iff the port addressed by `cfg_port` is in PASS.
- Accepting a request with `cfg_sel` equal to the current select is a no-op: state stays PASS, no fade.
- Accepting any other request:
  - `pending <= cfg_sel`, state goes to FADE_OUT, `g` is unchanged (full = 2^FADE_LOG2).
- FADE_OUT: `g` decrements by 1 per cycle; the edge that makes `g` = 0 also moves the state to SWITCH.
- SWITCH: lasts one cycle. `sel <= pending`, state goes to FADE_IN.
- FADE_IN: `g` increments by 1 per cycle; the edge that makes `g` full also moves the state to PASS.
- Output datapath, per port, registered:
  - `out <= (src[sel] * g) >>> FADE_LOG2`
  - signed product of width W+FADE_LOG2+1, arithmetic shift (floor), keep the low W bits.
  - At full gain the output equals the input exactly. At `g` = 0 the output is 0.
- Requests to a busy port are not accepted; `cfg_valid` must be held until `cfg_ready`. The other port is unaffected.
- Out-of-range `cfg_sel` (≥ NSRC) is accepted and ignored: no state change.
- Reset values:
  - both ports: state PASS, `g` full
  - `sel_a` = 0, `sel_b` = 1 (1 % NSRC), `pending` = reset select
  - `dac_a_out` = `dac_b_out` = 0, `busy_*` = 0

## Timing
- Source-to-output latency is 1 cycle.
- `sel` and `g` affect the output one cycle after they change.
- Switch with fade, with E0 = accept edge:
  - FADE_OUT from E0; `g` reaches 0 at E(2^F)
  - SWITCH → FADE_IN at E(2^F+1)
  - PASS at E(2^(F+1)+1)
  - For F = 4: `busy` high for 33 cycles.
- `rst` asserted mid-fade returns the port to PASS at full gain with the reset select immediately. The pending request is discarded.

## Configuration
- `DAC_SCHED_SOFT_FADE_EN`
  - Defined: fade sequence as above.
  - Undefined: FADE_OUT/FADE_IN are not built and `g` is constant full. An accepted request goes PASS → SWITCH → PASS, so `busy` is high for 1 cycle and the new source appears at the output 2 cycles after the accept edge.

## Structure
- Package `dac_sched_pkg` holds:
  - the state enum `port_state_t`
  - default constants for W, NSRC, FADE_LOG2
  - the full-gain localparam expression
- Sub-module `dac_port_seq` contains one port's FSM, gain counter, mux and scaled output register. The top instantiates it twice, decodes `cfg_port` and muxes `cfg_ready`.

## Test plan
- Reset: assert `rst` asynchronously between edges → all outputs take their reset values immediately; `sel_a` = 0, `sel_b` = 1, `cfg_ready` = 1.
- Passthrough: src0 = 0x1234, src1 = −5 → `dac_a_out` = 0x1234 and `dac_b_out` = −5 one cycle later.
- Fade: src0 = 1600, src2 = −1600; request port A → source 2 → `dac_a_out` goes 1600, 1500, …, 100, 0; then `sel_a` = 2; then −100, …, −1600; `busy_a` high for 33 cycles; `dac_b_out` unchanged throughout.
- Stall and no-op:
  - Port A request held while A is busy → `cfg_ready` = 0 until PASS, then accepted.
  - Request for the current source → `busy_a` stays 0.
- Reset mid-fade at `g` = 7 → `sel_a` = 0, full gain, `busy_a` = 0 immediately.
- Macro undefined: request A → source 3 → `busy_a` pulses for 1 cycle; `dac_a_out` equals src3 two cycles after accept, with no intermediate values.
